// File: rtl/bd_leaf_scheduler.sv
// Two-class (tag/spike vs. dump/warning) queueing scheduler for decoded BD words.
// Optional statistics counters are enabled with the macro BD_LEAF_SCHED_STATS_EN.
module bd_leaf_scheduler #(
    parameter int NCODE    = 4,
    parameter int NPAYLOAD = 38,
    parameter int HI_DEPTH = 16,
    parameter int LO_DEPTH = 8,
    parameter int HI_BURST = 4
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [NCODE+NPAYLOAD-1:0]     in_d,
    input  logic                          in_v,
    output logic                          in_a,
    output logic [NCODE+NPAYLOAD-1:0]     out_d,
    output logic                          out_v,
    input  logic                          out_a,
    output logic [$clog2(HI_DEPTH):0]     hi_count,
    output logic [$clog2(LO_DEPTH):0]     lo_count,
    output logic [15:0]                   inv_cnt,
    output logic [15:0]                   stall_cnt
);

    localparam int W   = NCODE + NPAYLOAD;
    localparam int HAW = $clog2(HI_DEPTH);
    localparam int LAW = $clog2(LO_DEPTH);
    localparam int RW  = $clog2(HI_BURST + 1);

    logic [NCODE-1:0] code;
    logic             is_hi;
    logic             is_lo;
    logic             is_inv;

    assign code = in_d[W-1 -: NCODE];

    always_comb begin
        is_hi  = (code == NCODE'(8)) || (code == NCODE'(11)) || (code == NCODE'(12));
        is_lo  = (code <= NCODE'(7)) || (code == NCODE'(9)) || (code == NCODE'(10));
        is_inv = !is_hi && !is_lo;
    end

    logic [W-1:0]   hi_mem_q [HI_DEPTH];
    logic [HAW-1:0] hi_wr_q;
    logic [HAW-1:0] hi_rd_q;
    logic [HAW:0]   hi_cnt_q;
    logic [HAW:0]   hi_cnt_d;
    logic           hi_full;
    logic           hi_ne;
    logic           push_hi;
    logic           pop_hi;

    logic [W-1:0]   lo_mem_q [LO_DEPTH];
    logic [LAW-1:0] lo_wr_q;
    logic [LAW-1:0] lo_rd_q;
    logic [LAW:0]   lo_cnt_q;
    logic [LAW:0]   lo_cnt_d;
    logic           lo_full;
    logic           lo_ne;
    logic           push_lo;
    logic           pop_lo;

    // Fullness uses the registered count only: a same-cycle pop does not free a slot.
    assign hi_full = (hi_cnt_q == (HAW+1)'(HI_DEPTH));
    assign lo_full = (lo_cnt_q == (LAW+1)'(LO_DEPTH));
    assign hi_ne   = (hi_cnt_q != '0);
    assign lo_ne   = (lo_cnt_q != '0);

    assign in_a    = in_v && (is_inv || (is_hi && !hi_full) || (is_lo && !lo_full));
    assign push_hi = in_a && is_hi;
    assign push_lo = in_a && is_lo;

    always_comb begin
        hi_cnt_d = hi_cnt_q;
        if (push_hi && !pop_hi) begin
            hi_cnt_d = hi_cnt_q + (HAW+1)'(1);
        end else if (!push_hi && pop_hi) begin
            hi_cnt_d = hi_cnt_q - (HAW+1)'(1);
        end
    end

    always_comb begin
        lo_cnt_d = lo_cnt_q;
        if (push_lo && !pop_lo) begin
            lo_cnt_d = lo_cnt_q + (LAW+1)'(1);
        end else if (!push_lo && pop_lo) begin
            lo_cnt_d = lo_cnt_q - (LAW+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (push_hi) begin
            hi_mem_q[hi_wr_q] <= in_d;
        end
        if (push_lo) begin
            lo_mem_q[lo_wr_q] <= in_d;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hi_wr_q  <= '0;
            hi_rd_q  <= '0;
            hi_cnt_q <= '0;
            lo_wr_q  <= '0;
            lo_rd_q  <= '0;
            lo_cnt_q <= '0;
        end else begin
            if (push_hi) hi_wr_q <= hi_wr_q + HAW'(1);
            if (pop_hi)  hi_rd_q <= hi_rd_q + HAW'(1);
            if (push_lo) lo_wr_q <= lo_wr_q + LAW'(1);
            if (pop_lo)  lo_rd_q <= lo_rd_q + LAW'(1);
            hi_cnt_q <= hi_cnt_d;
            lo_cnt_q <= lo_cnt_d;
        end
    end

    logic          load_en;
    logic          out_v_q;
    logic          out_v_d;
    logic [W-1:0]  out_d_q;
    logic [W-1:0]  out_d_d;
    logic [RW-1:0] hi_run_q;
    logic [RW-1:0] hi_run_d;

    // hi_run saturates at HI_BURST so a pending low word wins the very next load.
    always_comb begin
        load_en  = !out_v_q || out_a;
        pop_hi   = 1'b0;
        pop_lo   = 1'b0;
        out_v_d  = out_v_q;
        out_d_d  = out_d_q;
        hi_run_d = hi_run_q;
        if (load_en) begin
            if (hi_ne && (!lo_ne || (hi_run_q < RW'(HI_BURST)))) begin
                pop_hi   = 1'b1;
                out_v_d  = 1'b1;
                out_d_d  = hi_mem_q[hi_rd_q];
                hi_run_d = (hi_run_q == RW'(HI_BURST)) ? hi_run_q : hi_run_q + RW'(1);
            end else if (lo_ne) begin
                pop_lo   = 1'b1;
                out_v_d  = 1'b1;
                out_d_d  = lo_mem_q[lo_rd_q];
                hi_run_d = '0;
            end else begin
                out_v_d  = 1'b0;
                hi_run_d = '0;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_v_q  <= 1'b0;
            out_d_q  <= '0;
            hi_run_q <= '0;
        end else begin
            out_v_q  <= out_v_d;
            out_d_q  <= out_d_d;
            hi_run_q <= hi_run_d;
        end
    end

    assign out_v    = out_v_q;
    assign out_d    = out_d_q;
    assign hi_count = hi_cnt_q;
    assign lo_count = lo_cnt_q;

`ifdef BD_LEAF_SCHED_STATS_EN
    logic [15:0] inv_cnt_q;
    logic [15:0] stall_cnt_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            inv_cnt_q   <= '0;
            stall_cnt_q <= '0;
        end else begin
            if (in_v && is_inv && (inv_cnt_q != 16'hFFFF)) begin
                inv_cnt_q <= inv_cnt_q + 16'd1;
            end
            if (in_v && !in_a && (stall_cnt_q != 16'hFFFF)) begin
                stall_cnt_q <= stall_cnt_q + 16'd1;
            end
        end
    end

    assign inv_cnt   = inv_cnt_q;
    assign stall_cnt = stall_cnt_q;
`else
    assign inv_cnt   = 16'd0;
    assign stall_cnt = 16'd0;
`endif

endmodule

// File: tb/tb_bd_leaf_scheduler.sv
// Self-checking bench for bd_leaf_scheduler: directed table, corner sequences and a
// randomized run against a queue-based reference model.
module tb_bd_leaf_scheduler;

    localparam int NCODE    = 4;
    localparam int NPAYLOAD = 38;
    localparam int HI_DEPTH = 16;
    localparam int LO_DEPTH = 8;
    localparam int HI_BURST = 4;
    localparam int W        = NCODE + NPAYLOAD;
`ifdef BD_LEAF_SCHED_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic [W-1:0]  in_d;
    logic          in_v;
    logic          in_a;
    logic [W-1:0]  out_d;
    logic          out_v;
    logic          out_a;
    logic [4:0]    hi_count;
    logic [3:0]    lo_count;
    logic [15:0]   inv_cnt;
    logic [15:0]   stall_cnt;

    always #5 clk = ~clk;

    bd_leaf_scheduler #(
        .NCODE(NCODE), .NPAYLOAD(NPAYLOAD), .HI_DEPTH(HI_DEPTH),
        .LO_DEPTH(LO_DEPTH), .HI_BURST(HI_BURST)
    ) dut (
        .clk(clk), .reset(reset),
        .in_d(in_d), .in_v(in_v), .in_a(in_a),
        .out_d(out_d), .out_v(out_v), .out_a(out_a),
        .hi_count(hi_count), .lo_count(lo_count),
        .inv_cnt(inv_cnt), .stall_cnt(stall_cnt)
    );

    int checks   = 0;
    int failures = 0;

    // Reference model state
    logic [W-1:0] hq[$];
    logic [W-1:0] lq[$];
    bit           m_ov;
    logic [W-1:0] m_od;
    int           m_run;
    int           m_inv;
    int           m_stall;
    bit           m_ia;

    bit           seen_ia;
    bit           seen_ov;
    logic [W-1:0] seen_od;

    typedef struct {
        logic       v;
        logic [3:0] code;
        logic       oa;
        logic       ia;
        int         hi;
        int         lo;
        logic       ov;
    } vec_t;

    vec_t tbl[14];

    // 1 = high, 0 = low, 2 = invalid
    function automatic int cls(input logic [W-1:0] d);
        logic [3:0] c;
        c = d[W-1 -: 4];
        if (c == 4'd8 || c == 4'd11 || c == 4'd12) return 1;
        if (c <= 4'd10) return 0;
        return 2;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, req, $time);
        end
    endtask

    task automatic model_reset();
        hq.delete();
        lq.delete();
        m_ov    = 1'b0;
        m_od    = '0;
        m_run   = 0;
        m_inv   = 0;
        m_stall = 0;
    endtask

    task automatic model_check();
        int c;
        c = cls(in_d);
        m_ia = in_v && (c == 2 || (c == 1 && hq.size() < HI_DEPTH) || (c == 0 && lq.size() < LO_DEPTH));
        seen_ia = in_a;
        seen_ov = out_v;
        seen_od = out_d;
        chk("m_in_a", in_a, m_ia);
        chk("m_out_v", out_v, m_ov);
        chk("m_out_d", out_d, m_od);
        chk("m_hi_count", hi_count, hq.size());
        chk("m_lo_count", lo_count, lq.size());
        chk("m_inv_cnt", inv_cnt, STATS ? m_inv : 0);
        chk("m_stall_cnt", stall_cnt, STATS ? m_stall : 0);
    endtask

    task automatic model_update(input logic v, input logic [W-1:0] d, input logic oa);
        if (!m_ov || oa) begin
            if (hq.size() > 0 && (lq.size() == 0 || m_run < HI_BURST)) begin
                m_od  = hq.pop_front();
                m_ov  = 1'b1;
                m_run = (m_run + 1 > HI_BURST) ? HI_BURST : m_run + 1;
            end else if (lq.size() > 0) begin
                m_od  = lq.pop_front();
                m_ov  = 1'b1;
                m_run = 0;
            end else begin
                m_ov  = 1'b0;
                m_run = 0;
            end
        end
        if (v && m_ia) begin
            if (cls(d) == 1) hq.push_back(d);
            else if (cls(d) == 0) lq.push_back(d);
        end
        if (v && cls(d) == 2 && m_inv < 65535) m_inv++;
        if (v && !m_ia && m_stall < 65535) m_stall++;
    endtask

    // Called at posedge+1; returns at the next posedge+1.
    task automatic cycle(input logic v, input logic [W-1:0] d, input logic oa);
        in_v  = v;
        in_d  = d;
        out_a = oa;
        @(negedge clk);
        model_check();
        @(posedge clk);
        model_update(v, d, oa);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        in_v  = 1'b0;
        in_d  = '0;
        out_a = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;
    endtask

    initial begin
        int acked;
        int got;
        int cnt;
        bit sent;
        string seq;
        logic [63:0] r;
        logic [3:0] hcodes [3];

        tbl[0]  = '{1'b1, 4'd13, 1'b0, 1'b1, 0, 0, 1'b0};
        tbl[1]  = '{1'b1, 4'd8,  1'b0, 1'b1, 1, 0, 1'b0};
        tbl[2]  = '{1'b1, 4'd0,  1'b0, 1'b1, 0, 1, 1'b1};
        tbl[3]  = '{1'b1, 4'd14, 1'b0, 1'b1, 0, 1, 1'b1};
        tbl[4]  = '{1'b1, 4'd9,  1'b0, 1'b1, 0, 2, 1'b1};
        tbl[5]  = '{1'b1, 4'd11, 1'b0, 1'b1, 1, 2, 1'b1};
        tbl[6]  = '{1'b1, 4'd15, 1'b0, 1'b1, 1, 2, 1'b1};
        tbl[7]  = '{1'b1, 4'd12, 1'b0, 1'b1, 2, 2, 1'b1};
        tbl[8]  = '{1'b1, 4'd10, 1'b0, 1'b1, 2, 3, 1'b1};
        tbl[9]  = '{1'b1, 4'd7,  1'b0, 1'b1, 2, 4, 1'b1};
        tbl[10] = '{1'b1, 4'd1,  1'b0, 1'b1, 2, 5, 1'b1};
        tbl[11] = '{1'b0, 4'd3,  1'b1, 1'b0, 1, 5, 1'b1};
        tbl[12] = '{1'b1, 4'd2,  1'b1, 1'b1, 0, 6, 1'b1};
        tbl[13] = '{1'b0, 4'd0,  1'b1, 1'b0, 0, 5, 1'b1};
        hcodes[0] = 4'd8;
        hcodes[1] = 4'd11;
        hcodes[2] = 4'd12;

        in_v  = 1'b0;
        in_d  = '0;
        out_a = 1'b0;
        model_reset();
        #1 reset = 1'b1;
        #1;
        chk("rst_out_v", out_v, 0);
        chk("rst_out_d", out_d, 0);
        chk("rst_hi_count", hi_count, 0);
        chk("rst_lo_count", lo_count, 0);
        chk("rst_inv_cnt", inv_cnt, 0);
        chk("rst_stall_cnt", stall_cnt, 0);
        chk("rst_in_a", in_a, 0);
        do_reset();

        // Latency: accepted at edge t, visible after edge t+1
        cycle(1'b1, {4'd12, 38'h5}, 1'b1);
        chk("lat_in_a", seen_ia, 1);
        chk("lat_out_v_t1", out_v, 0);
        chk("lat_hi_t1", hi_count, 1);
        cycle(1'b0, '0, 1'b1);
        chk("lat_out_v_t2", out_v, 1);
        chk("lat_out_d", out_d, {4'd12, 38'h5});
        chk("lat_hi_t2", hi_count, 0);
        cycle(1'b0, '0, 1'b1);
        chk("lat_out_v_t3", out_v, 0);

        // Classification table
        do_reset();
        for (int i = 0; i < 14; i++) begin
            cycle(tbl[i].v, {tbl[i].code, 38'(i)}, tbl[i].oa);
            chk($sformatf("tbl%0d_in_a", i), seen_ia, tbl[i].ia);
            chk($sformatf("tbl%0d_hi", i), hi_count, tbl[i].hi);
            chk($sformatf("tbl%0d_lo", i), lo_count, tbl[i].lo);
            chk($sformatf("tbl%0d_out_v", i), out_v, tbl[i].ov);
        end
        chk("tbl_inv_cnt", inv_cnt, STATS ? 3 : 0);
        repeat (30) cycle(1'b0, '0, 1'b1);

        // Fill high FIFO (plus the output register), then stall
        do_reset();
        acked = 0;
        for (int i = 0; i < 17; i++) begin
            cycle(1'b1, {4'd11, 38'(i)}, 1'b0);
            if (seen_ia) acked++;
        end
        chk("fill_acked", acked, 17);
        chk("fill_hi_count", hi_count, 16);
        for (int i = 0; i < 3; i++) begin
            cycle(1'b1, {4'd11, 38'd17}, 1'b0);
            chk("stall_in_a", seen_ia, 0);
        end
        chk("stall_cnt", stall_cnt, STATS ? 3 : 0);
        got  = 0;
        sent = 1'b0;
        for (int n = 0; n < 80 && got < 18; n++) begin
            cycle(!sent, {4'd11, 38'd17}, 1'b1);
            if (!sent && seen_ia) sent = 1'b1;
            if (seen_ov) begin
                chk("fill_order", seen_od, {4'd11, 38'(got)});
                got++;
            end
        end
        chk("fill_drained", got, 18);

        // Bounded burst
        do_reset();
        for (int i = 0; i < 10; i++) cycle(1'b1, {hcodes[i % 3], 38'(i)}, 1'b0);
        for (int i = 0; i < 3; i++) cycle(1'b1, {4'(i), 38'(100 + i)}, 1'b0);
        seq = "";
        for (int n = 0; n < 40 && seq.len() < 13; n++) begin
            cycle(1'b0, '0, 1'b1);
            if (seen_ov) seq = {seq, (cls(seen_od) == 1) ? "H" : "L"};
        end
        checks++;
        if (seq != "HHHHLHHHHLHHL") begin
            failures++;
            $display("FAIL burst_seq actual=%s required=HHHHLHHHHLHHL", seq);
        end

        // Full low FIFO: push blocked while a pop frees a slot
        do_reset();
        for (int i = 0; i < 9; i++) cycle(1'b1, {4'd0, 38'(i)}, 1'b0);
        chk("lo_full_count", lo_count, 8);
        cycle(1'b1, {4'd0, 38'd99}, 1'b1);
        chk("lo_full_in_a", seen_ia, 0);
        chk("lo_pop_count", lo_count, 7);
        repeat (20) cycle(1'b0, '0, 1'b1);

        // Reset with queued words and a held output
        do_reset();
        for (int i = 0; i < 5; i++) cycle(1'b1, {(i % 2 == 1) ? 4'd3 : 4'd8, 38'(i)}, 1'b0);
        chk("pre_rst_out_v", out_v, 1);
        in_v  = 1'b0;
        out_a = 1'b0;
        #2 reset = 1'b1;
        #1;
        chk("mid_rst_out_v", out_v, 0);
        chk("mid_rst_out_d", out_d, 0);
        chk("mid_rst_hi", hi_count, 0);
        chk("mid_rst_lo", lo_count, 0);
        model_reset();
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;
        cnt = 0;
        for (int n = 0; n < 10; n++) begin
            cycle(1'b0, '0, 1'b1);
            if (seen_ov) cnt++;
        end
        chk("post_rst_no_output", cnt, 0);

        // Randomized run against the model
        do_reset();
        for (int n = 0; n < 4000; n++) begin
            logic v;
            logic oa;
            int   code;
            v    = ($urandom_range(0, 3) != 0);
            oa   = ((n / 150) % 2 == 1) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 3) == 0);
            code = $urandom_range(0, 15);
            r    = {$urandom, $urandom};
            cycle(v, {4'(code), r[37:0]}, oa);
        end
        repeat (30) cycle(1'b0, '0, 1'b1);
        chk("final_hi_empty", hi_count, 0);
        chk("final_lo_empty", lo_count, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
